// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl -- bit-serial add sequencer
//
// Accepts one WIDTH-bit operand pair on a valid/ready handshake, then steps a
// single 1-bit full-adder cell (full_add) over the operand bits LSB first,
// one bit per clock, with a registered carry between bits. The finished sum
// and final carry are offered on an output valid/ready handshake.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   defined   : op_sub=1 at acceptance computes op_a - op_b (carry_out is the
//               no-borrow flag, 1 iff op_a >= op_b unsigned).
//   undefined : op_sub is ignored and every operation is an add.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   op_a/op_b  operands, WIDTH bits
//   op_sub     subtract request (only with SERIAL_ADD_SUB_EN)
//   out_valid  result/carry_out valid (DONE only)
//   out_ready  consumer accepts the result
//   result     sum or difference mod 2^WIDTH
//   carry_out  final carry from the MSB position
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------

// 1-bit full-adder cell shared across all bit positions
module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] res_r;
   logic             c_r;
   logic [CW-1:0]    cnt_r;

   logic             sub_s;
   logic             accept_s;
   logic             last_s;
   logic             sum_s;
   logic             cout_s;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_s = op_sub;
`else
   // op_sub stays on the port for a uniform interface but has no function
   logic unused_op_sub_s;
   assign unused_op_sub_s = op_sub;
   assign sub_s           = 1'b0;
`endif

   assign accept_s = (state_r == IDLE) && in_valid;
   assign last_s   = (cnt_r == CW'(WIDTH - 1));

   full_add u_full_add (
      .a    (sa_r[0]),
      .b    (sb_r[0]),
      .cin  (c_r),
      .sum  (sum_s),
      .cout (cout_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Operand shift registers, carry, bit counter and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_r  <= {WIDTH{1'b0}};
         sb_r  <= {WIDTH{1'b0}};
         res_r <= {WIDTH{1'b0}};
         c_r   <= 1'b0;
         cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
         // Subtraction is a + ~b + 1: invert SB and seed the carry with 1
         sa_r  <= op_a;
         sb_r  <= sub_s ? ~op_b : op_b;
         c_r   <= sub_s;
         cnt_r <= {CW{1'b0}};
      end else if (state_r == RUN) begin
         sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
         sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
         res_r <= {sum_s, res_r[WIDTH-1:1]};
         c_r   <= cout_s;
         // Wrap to zero on the last bit so the counter never passes WIDTH-1
         cnt_r <= last_s ? {CW{1'b0}} : cnt_r + 1'b1;
      end else begin
         sa_r  <= sa_r;
         sb_r  <= sb_r;
         res_r <= res_r;
         c_r   <= c_r;
         cnt_r <= cnt_r;
      end
   end

   assign result    = res_r;
   assign carry_out = c_r;
   assign out_valid = (state_r == DONE);
   assign busy      = (state_r != IDLE);
   assign in_ready  = (state_r == IDLE);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add sequencer. It accepts one WIDTH-bit operand pair through a valid/ready handshake and steps a single 1-bit full-adder cell (full_add, instantiated inside) over the operand bits, LSB first, one bit per clock. A registered carry feeds the adder between bits. The finished sum and final carry are presented on an output valid/ready handshake. This lets a narrow datapath share one full-adder cell for multi-bit arithmetic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset; clears all state immediately.
in_valid  input  1  operand pair on op_a/op_b/op_sub is valid.
in_ready  output  1  block can accept an operand pair; high only in IDLE.
op_a  input  WIDTH  first operand.
op_b  input  WIDTH  second operand.
op_sub  input  1  subtract request; used only when SUB_EN is defined, otherwise ignored.
out_valid  output  1  result and carry_out are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  sum or difference, mod 2^WIDTH.
carry_out  output  1  final carry from the MSB position.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; shift registers, result, carry register, bit counter all 0. Outputs: out_valid=0, result=0, carry_out=0, busy=0, in_ready=1.
- Reset mid-operation aborts the operation. The partial result is discarded, and no out_valid is produced for the aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: latch op_a into shift register SA and op_b into SB (SB is bit-inverted if subtracting). Carry register C=0 for add, 1 for subtract. Counter=0. Go to RUN.
  - in_valid=0: stay in IDLE.
- RUN, each edge:
  - The full_add cell computes from SA[0], SB[0], C.
  - Its sum bit shifts into result at the MSB; result shifts right.
  - SA and SB shift right; C takes cout; counter increments.
  - When the counter reaches WIDTH-1 on this edge (the last bit is processed), go to DONE.
  - RUN lasts exactly WIDTH edges. out_valid is visible after the WIDTH-th edge following the accepting edge.
- DONE:
  - out_valid=1; result and carry_out (=C) are held stable.
  - out_ready=1 on an edge: go to IDLE. out_valid falls, result holds its last value.
  - out_ready=0: stay in DONE indefinitely.
- in_valid is ignored outside IDLE. There is no accept on the same edge as the output handshake, so there is a minimum of one IDLE cycle between operations.
- Changes to op_a, op_b or op_sub after acceptance have no effect.
- Arithmetic: result = (op_a + op_b) mod 2^WIDTH; carry_out = bit WIDTH of the full sum.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1.
- busy = (state != IDLE); in_ready = (state == IDLE). Both are decoded from the state register, with no combinational path from the inputs.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: when op_sub=1 at acceptance, SB is loaded with ~op_b and C with 1. Then result = (op_a - op_b) mod 2^WIDTH and carry_out = no-borrow flag (1 iff op_a >= op_b, unsigned).
- Not defined: op_sub is ignored; SB=op_b and C=0 always. The port remains present, undriven internally.

Test Plan:
1. Simple add, WIDTH=8: op_a=0x05, op_b=0x03, out_ready=1 -> out_valid rises 8 edges after accept; result=0x08, carry_out=0; back in IDLE one edge later.
2. Overflow: op_a=0xFF, op_b=0x01 -> result=0x00, carry_out=1. Also op_a=0xAA, op_b=0x55 -> result=0xFF, carry_out=0.
3. Backpressure: 0x10+0x20 with out_ready=0 for 5 cycles in DONE, in_valid=1 throughout -> result=0x30 stable, out_valid=1, in_ready=0, no new accept; out_ready=1 -> IDLE; next operand accepted the following edge.
4. Reset mid-op: assert rst_n=0 after the 4th RUN edge -> outputs immediately 0, in_ready=1, busy=0; after release, a new 0x01+0x01 yields 0x02 with no stale out_valid.
5. SERIAL_ADD_SUB_EN defined: 0x10-0x01 -> result=0x0F, carry_out=1; 0x01-0x02 -> result=0xFF, carry_out=0. Undefined: op_sub=1 with 0x10,0x01 -> result=0x11.
6. Back-to-back, in_valid held high with out_ready=1: operations separated by exactly one IDLE cycle; period = WIDTH+2 edges per operation; results correct for 0x7F+0x01=0x80 then 0x80+0x80=0x00, carry 1.
